// File: rtl/sram_pixel_streamer_if.sv
// Bus between the frame-read streamer and its environment: the SRAM read port and the pixel stream.
// The master side is the streamer; the slave side is the SRAM plus the downstream pixel consumer.
interface sram_pixel_streamer_if #(
  parameter int ADDR_SZ   = 16,
  parameter int RAM_WIDTH = 32
);
  logic                 sram_en;
  logic                 sram_we;
  logic [ADDR_SZ-1:0]   sram_addr;
  logic [RAM_WIDTH-1:0] sram_rdata;

  logic                 m_valid;
  logic                 m_ready;
  logic [23:0]          m_data;
  logic                 m_sof;
  logic                 m_eol;
  logic                 m_last;

  modport master (
    output sram_en, sram_we, sram_addr,
    input  sram_rdata,
    output m_valid, m_data, m_sof, m_eol, m_last,
    input  m_ready
  );

  modport slave (
    input  sram_en, sram_we, sram_addr,
    output sram_rdata,
    input  m_valid, m_data, m_sof, m_eol, m_last,
    output m_ready
  );
endinterface

// File: rtl/sram_pixel_streamer.sv
// Reads one IMG_W x IMG_H frame from a 1-cycle-latency SRAM in raster order and streams 24-bit pixels.
// Define PIXEL_CHECKSUM_EN to add a mod-2**32 checksum of every transferred pixel.
module sram_pixel_streamer #(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int ADDR_SZ   = 16,
  parameter int RAM_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef PIXEL_CHECKSUM_EN
  output logic [31:0] checksum,
`endif
  sram_pixel_streamer_if.master bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef struct packed { logic sof; logic eol; logic last; } mark_t;
  typedef struct packed { logic [23:0] data; mark_t mark; } pix_t;

  state_t             state, state_nxt;
  logic [XW-1:0]      x_cnt;
  logic [YW-1:0]      y_cnt;
  logic [ADDR_SZ-1:0] rd_addr;
  logic               inflight;
  mark_t              infl_mark, cur_mark;
  pix_t               fifo_mem [2];
  pix_t               head;
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic [2:0]         level_after;
  logic               accept, pop, issue, at_last;
  logic               unused_rdata;

  assign accept  = (state == S_IDLE) && start;
  assign pop     = (count != 2'd0) && bus.m_ready;
  // Entries held plus the read in flight, once this cycle's push and pop have settled.
  assign level_after = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue   = (state == S_RUN) && (level_after < 3'd2);
  assign at_last = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign cur_mark = '{sof: (x_cnt == '0) && (y_cnt == '0), eol: (x_cnt == X_LAST), last: at_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (issue && at_last) state_nxt = S_DRAIN;
      S_DRAIN: if (level_after == 3'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    bus.sram_en   = issue;
    bus.sram_we   = 1'b0;
    bus.sram_addr = rd_addr;
  end

  // Raster counters stop on the last pixel so the final address stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      rd_addr <= '0;
    end else if (accept) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      rd_addr <= '0;
    end else if (issue && !at_last) begin
      rd_addr <= rd_addr + ADDR_SZ'(1);
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      infl_mark <= '0;
    end else begin
      inflight <= issue;
      if (issue) infl_mark <= cur_mark;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= level_after[1:0];
    end
  end

  // NOTE: FIFO storage has no reset; count alone decides which entries are visible.
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= '{data: bus.sram_rdata[23:0], mark: infl_mark};
  end

  assign head        = fifo_mem[rd_ptr];
  assign bus.m_valid = (count != 2'd0);
  assign bus.m_data  = head.data;
  assign bus.m_sof   = head.mark.sof;
  assign bus.m_eol   = head.mark.eol;
  assign bus.m_last  = head.mark.last;

  assign unused_rdata = ^bus.sram_rdata[RAM_WIDTH-1:24];

`ifdef PIXEL_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         checksum <= '0;
    else if (accept) checksum <= '0;
    else if (pop)    checksum <= checksum + 32'(bus.m_data);
  end
`endif

endmodule

// File: tb/tb_sram_pixel_streamer.sv
// Directed bench: a 4x2 instance for latency/stall/restart/reset cases and a default 256x256
// instance for the full-frame run; each instance has its own SRAM model.
module tb_sram_pixel_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- small 4x2 instance ----------------
  logic s_rst, s_start, s_busy, s_done;
  sram_pixel_streamer_if #(.ADDR_SZ(16), .RAM_WIDTH(32)) s_if ();
`ifdef PIXEL_CHECKSUM_EN
  logic [31:0] s_csum;
`endif
  sram_pixel_streamer #(.IMG_W(4), .IMG_H(2), .ADDR_SZ(16), .RAM_WIDTH(32)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
`ifdef PIXEL_CHECKSUM_EN
    .checksum(s_csum),
`endif
    .bus(s_if.master)
  );
  always @(posedge clk) if (s_if.sram_en) s_if.sram_rdata <= 32'hFF000000 | 32'(s_if.sram_addr);

  // ---------------- default 256x256 instance ----------------
  logic l_rst, l_start, l_busy, l_done;
  sram_pixel_streamer_if #(.ADDR_SZ(16), .RAM_WIDTH(32)) l_if ();
`ifdef PIXEL_CHECKSUM_EN
  logic [31:0] l_csum;
`endif
  sram_pixel_streamer dut_l (
    .clk(clk), .rst(l_rst), .start(l_start), .busy(l_busy), .done(l_done),
`ifdef PIXEL_CHECKSUM_EN
    .checksum(l_csum),
`endif
    .bus(l_if.master)
  );
  always @(posedge clk) if (l_if.sram_en) l_if.sram_rdata <= 32'(l_if.sram_addr);

  // ---------------- monitors (sample on falling edge) ----------------
  logic [23:0] s_q_data[$];
  bit          s_q_sof[$], s_q_eol[$], s_q_last[$];
  int          s_q_cyc[$], s_q_addr[$];
  int          s_done_cnt = 0, s_done_cyc = 0, s_out = 0, we_bad = 0;
  bit          s_stall = 0, s_pop;
  logic [26:0] s_hold;

  always @(negedge clk) begin
    if (s_if.sram_we !== 1'b0) we_bad++;
    if (l_if.sram_we !== 1'b0) we_bad++;
    if (s_rst) begin
      s_out   = 0;
      s_stall = 0;
    end else begin
      s_pop = s_if.m_valid && s_if.m_ready;
      if (s_stall) begin
        check("stall_valid", s_if.m_valid, 1);
        check("stall_hold", {s_if.m_data, s_if.m_sof, s_if.m_eol, s_if.m_last}, s_hold);
      end
      if (s_if.sram_en) begin
        check("issue_room", 32'((s_out - int'(s_pop)) < 2), 1);
        s_q_addr.push_back(int'(s_if.sram_addr));
      end
      if (s_pop) begin
        s_q_data.push_back(s_if.m_data);
        s_q_sof.push_back(s_if.m_sof);
        s_q_eol.push_back(s_if.m_eol);
        s_q_last.push_back(s_if.m_last);
        s_q_cyc.push_back(cyc);
      end
      if (s_done) begin
        s_done_cnt++;
        s_done_cyc = cyc;
      end
      s_out   = s_out + int'(s_if.sram_en) - int'(s_pop);
      s_stall = s_if.m_valid && !s_if.m_ready;
      s_hold  = {s_if.m_data, s_if.m_sof, s_if.m_eol, s_if.m_last};
    end
  end

  int l_xfer = 0, l_bad = 0, l_eol = 0, l_sof = 0, l_last = 0, l_done_cnt = 0, l_last_addr = -1;
  always @(negedge clk) begin
    if (!l_rst) begin
      if (l_if.sram_en) l_last_addr = int'(l_if.sram_addr);
      if (l_if.m_valid && l_if.m_ready) begin
        if (l_if.m_data !== 24'(l_xfer)) l_bad++;
        if (l_if.m_eol)  l_eol++;
        if (l_if.m_sof)  l_sof++;
        if (l_if.m_last) l_last++;
        l_xfer++;
      end
      if (l_done) l_done_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_q();
    s_q_data.delete(); s_q_sof.delete(); s_q_eol.delete();
    s_q_last.delete(); s_q_cyc.delete(); s_q_addr.delete();
  endtask

  task automatic pulse_start(output int t0);
    s_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating. restart_k re-pulses start.
  task automatic run_small(input int budget, input int mode, input int restart_k);
    int k = 0;
    int d0 = s_done_cnt;
    while (s_done_cnt == d0 && k < budget) begin
      s_if.m_ready = (mode == 0) || (k % 3 == 0);
      s_start      = (k == restart_k);
      @(posedge clk); #1;
      k++;
    end
    s_start = 1'b0;
    s_if.m_ready = 1'b1;
    check("done_seen", s_done_cnt - d0, 1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nxfer"}, s_q_data.size(), 8);
    check({tag, "_naddr"}, s_q_addr.size(), 8);
    for (int i = 0; i < 8 && i < s_q_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), s_q_data[i], i);
      check($sformatf("%s_sof%0d", tag, i), s_q_sof[i], (i == 0));
      check($sformatf("%s_eol%0d", tag, i), s_q_eol[i], (i % 4 == 3));
      check($sformatf("%s_last%0d", tag, i), s_q_last[i], (i == 7));
    end
    for (int i = 0; i < 8 && i < s_q_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), s_q_addr[i], i);
    if (s_q_cyc.size() == 8) check({tag, "_done_after_last"}, s_done_cyc, s_q_cyc[7] + 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, d0, k;
    s_rst = 1'b1; l_rst = 1'b1; s_start = 1'b0; l_start = 1'b0;
    s_if.m_ready = 1'b1; l_if.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  s_busy, 0);
    check("rst_done",  s_done, 0);
    check("rst_en",    s_if.sram_en, 0);
    check("rst_we",    s_if.sram_we, 0);
    check("rst_addr",  s_if.sram_addr, 0);
    check("rst_valid", s_if.m_valid, 0);
    s_rst = 1'b0; l_rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: ready high, latency and markers
    clear_q();
    pulse_start(t0);
    check("t1_busy_T1", s_busy, 1);
    check("t1_en_T1", s_if.sram_en, 1);
    check("t1_addr_T1", s_if.sram_addr, 0);
    check("t1_valid_T1", s_if.m_valid, 0);
    run_small(40, 0, -1);
    check_frame("t1");
    for (int i = 0; i < 8 && i < s_q_cyc.size(); i++)
      check($sformatf("t1_cyc%0d", i), s_q_cyc[i], t0 + 3 + i);
    check("t1_busy_after", s_busy, 0);
`ifdef PIXEL_CHECKSUM_EN
    check("t1_checksum", s_csum, 28);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Test 2: ready toggling 1,0,0
    clear_q();
    pulse_start(t0);
    run_small(80, 1, -1);
    check_frame("t2");
    repeat (2) @(posedge clk);
    #1;

    // Test 3: second start during busy is ignored
    clear_q();
    d0 = s_done_cnt;
    pulse_start(t0);
    run_small(40, 0, 4);
    repeat (6) @(posedge clk);
    #1;
    check_frame("t3");
    check("t3_one_done", s_done_cnt - d0, 1);
    check("t3_idle", s_busy, 0);

    // Test 4: reset after three transfers, then a clean restart
    clear_q();
    pulse_start(t0);
    k = 0;
    while (s_q_data.size() < 3 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("t4_three_xfers", s_q_data.size(), 3);
    d0 = s_done_cnt;
    s_rst = 1'b1;
    #1;
    check("t4_valid_rst", s_if.m_valid, 0);
    check("t4_busy_rst", s_busy, 0);
    check("t4_en_rst", s_if.sram_en, 0);
    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_done", s_done_cnt - d0, 0);
    check("t4_valid_idle", s_if.m_valid, 0);
    clear_q();
    pulse_start(t0);
    check("t4_restart_addr", s_if.sram_addr, 0);
    run_small(40, 0, -1);
    check_frame("t4");

    // Test 5: full default frame
    l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    k = 0;
    while (l_done_cnt == 0 && k < 70000) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_done", l_done_cnt, 1);
    check("t5_xfers", l_xfer, 65536);
    check("t5_data_errors", l_bad, 0);
    check("t5_eol_count", l_eol, 256);
    check("t5_sof_count", l_sof, 1);
    check("t5_last_count", l_last, 1);
    check("t5_last_addr", l_last_addr, 32'h0000FFFF);
`ifdef PIXEL_CHECKSUM_EN
    check("t5_checksum", l_csum, 32'h7FFF8000);
`endif

    // Test 6: write enable never asserted
    check("we_always_0", we_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
